// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS pipeline boundary registers.
// Holds the fetch entry record, IF/ID buffer state encoding and reset defaults.
package mips_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [ADDR_W_DEF-1:0] pc_plus4;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_t;

  function automatic fetch_entry_t reset_entry(input logic [DATA_W_DEF-1:0] nop);
    fetch_entry_t e;
    e.pc       = '0;
    e.pc_plus4 = ADDR_W_DEF'(4);
    e.instr    = nop;
    return e;
  endfunction

endpackage

// File: rtl/ifid_entry_reg.sv
// Load-enabled fetch entry register with synchronous reset.
// Used for both the head and skid slots of the IF/ID buffer.
module ifid_entry_reg
  import mips_pkg::*;
#(
  parameter fetch_entry_t RST_VAL = reset_entry(NOP_INSTR_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  fetch_entry_t d,
  output fetch_entry_t q
);

  fetch_entry_t entry_d;
  fetch_entry_t entry_q;

  always_comb begin
    entry_d = entry_q;
    if (load) entry_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) entry_q <= RST_VAL;
    else       entry_q <= entry_d;
  end

  assign q = entry_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary: 2-entry skid buffer between fetch and decode.
// if_ready is decoded from registered state only, so decode stalls never reach the PC.
//
//   state | meaning
//   EMPTY | nothing held, id_valid=0, id_instr forced to NOP
//   ONE   | head holds the oldest entry, skid free
//   TWO   | head and skid both full (skid younger), if_ready=0
module if_id_skid_reg
  import mips_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [DATA_W-1:0] id_instr,
  output logic [1:0]        occupancy
);

  localparam fetch_entry_t RST_ENTRY = reset_entry(NOP_INSTR);

  ifid_state_t  state_d, state_q;
  fetch_entry_t in_entry, head_din, head_q, skid_q;
  logic         head_load, skid_load;
  logic         push, pop;

  assign if_ready = (state_q != TWO);
  assign id_valid = (state_q != EMPTY);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  // pc+4 is computed at capture so id_pc_plus4 comes straight off a flop
  always_comb begin
    in_entry.pc       = if_pc;
    in_entry.pc_plus4 = if_pc + ADDR_W'(4);
    in_entry.instr    = if_instr;
  end

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    skid_load = 1'b0;
    head_din  = in_entry;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = ONE;
          head_load = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          state_d   = TWO;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          head_load = 1'b1;
          head_din  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // head keeps its contents on flush so id_pc holds while EMPTY
    if (flush) begin
      state_d   = EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  ifid_entry_reg #(.RST_VAL(RST_ENTRY)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .d     (head_din),
    .q     (head_q)
  );

  ifid_entry_reg #(.RST_VAL(RST_ENTRY)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign id_pc       = head_q.pc;
  assign id_pc_plus4 = head_q.pc_plus4;
  assign id_instr    = id_valid ? head_q.instr : NOP_INSTR;
  assign occupancy   = state_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for the IF/ID skid buffer: vector table plus hand sequences.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_pc, if_instr, id_pc, id_pc_plus4, id_instr;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .occupancy   (occupancy)
  );

  typedef struct {
    logic        rst, vld, fl, rdy;
    logic [31:0] pc, ins;
    logic [1:0]  e_occ;
    logic        e_vld, e_rdy;
    logic [31:0] e_pc, e_p4, e_ins;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, vld, fl, rdy, input logic [31:0] pc, ins,
                              input logic [1:0] e_occ, input logic e_vld, e_rdy,
                              input logic [31:0] e_pc, e_p4, e_ins);
    vec_t v;
    v.rst = rst; v.vld = vld; v.fl = fl; v.rdy = rdy; v.pc = pc; v.ins = ins;
    v.e_occ = e_occ; v.e_vld = e_vld; v.e_rdy = e_rdy;
    v.e_pc = e_pc; v.e_p4 = e_p4; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] occ, input logic vld, rdy,
                           input logic [31:0] pc, p4, ins);
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    chk({tag, ".id_valid"},  32'(id_valid),  32'(vld));
    chk({tag, ".if_ready"},  32'(if_ready),  32'(rdy));
    chk({tag, ".id_pc"},     id_pc,          pc);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4,  p4);
    chk({tag, ".id_instr"},  id_instr,       ins);
  endtask

  task automatic drive(input logic rst, vld, fl, rdy, input logic [31:0] pc, ins);
    reset = rst; if_valid = vld; flush = fl; id_ready = rdy; if_pc = pc; if_instr = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held 2 cycles, then released
    vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,        0,0,1, 32'h0,        32'h4,        32'h0));
    vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,        0,0,1, 32'h0,        32'h4,        32'h0));
    vecs.push_back(mk(0,0,0,0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0,1, 32'h0,        32'h4,        32'h0));
    // streaming with id_ready=1
    vecs.push_back(mk(0,1,0,1, 32'h00400000, 32'h11111111, 1,1,1, 32'h00400000, 32'h00400004, 32'h11111111));
    vecs.push_back(mk(0,1,0,1, 32'h00400004, 32'h22222222, 1,1,1, 32'h00400004, 32'h00400008, 32'h22222222));
    vecs.push_back(mk(0,1,0,1, 32'h00400008, 32'h33333333, 1,1,1, 32'h00400008, 32'h0040000C, 32'h33333333));
    vecs.push_back(mk(0,0,0,1, 32'h0,        32'h0,        0,0,1, 32'h00400008, 32'h0040000C, 32'h0));
    // fill both slots with decode stalled, then drain in order
    vecs.push_back(mk(0,1,0,0, 32'h00400000, 32'hAAAA0000, 1,1,1, 32'h00400000, 32'h00400004, 32'hAAAA0000));
    vecs.push_back(mk(0,1,0,0, 32'h00400004, 32'hBBBB0004, 2,1,0, 32'h00400000, 32'h00400004, 32'hAAAA0000));
    vecs.push_back(mk(0,1,0,0, 32'h00400008, 32'hCCCC0008, 2,1,0, 32'h00400000, 32'h00400004, 32'hAAAA0000));
    vecs.push_back(mk(0,0,0,1, 32'h0,        32'h0,        1,1,1, 32'h00400004, 32'h00400008, 32'hBBBB0004));
    vecs.push_back(mk(0,0,0,1, 32'h0,        32'h0,        0,0,1, 32'h00400004, 32'h00400008, 32'h0));
    // flush with two held and a same-cycle offer
    vecs.push_back(mk(0,1,0,0, 32'h00400020, 32'hD0D0D0D0, 1,1,1, 32'h00400020, 32'h00400024, 32'hD0D0D0D0));
    vecs.push_back(mk(0,1,0,0, 32'h00400024, 32'hD1D1D1D1, 2,1,0, 32'h00400020, 32'h00400024, 32'hD0D0D0D0));
    vecs.push_back(mk(0,1,1,0, 32'h00400010, 32'hEEEEEEEE, 0,0,1, 32'h00400020, 32'h00400024, 32'h0));
    vecs.push_back(mk(0,0,0,1, 32'h0,        32'h0,        0,0,1, 32'h00400020, 32'h00400024, 32'h0));
    // flush in ONE with push and pop in the same cycle
    vecs.push_back(mk(0,1,0,0, 32'h00400030, 32'hF0F0F0F0, 1,1,1, 32'h00400030, 32'h00400034, 32'hF0F0F0F0));
    vecs.push_back(mk(0,1,1,1, 32'h00400034, 32'hF4F4F4F4, 0,0,1, 32'h00400030, 32'h00400034, 32'h0));
    // pc+4 wraps
    vecs.push_back(mk(0,1,0,1, 32'hFFFFFFFC, 32'h12345678, 1,1,1, 32'hFFFFFFFC, 32'h00000000, 32'h12345678));
    vecs.push_back(mk(0,0,0,1, 32'h0,        32'h0,        0,0,1, 32'hFFFFFFFC, 32'h00000000, 32'h0));
    // reset and flush together
    vecs.push_back(mk(0,1,0,0, 32'h00400040, 32'h40404040, 1,1,1, 32'h00400040, 32'h00400044, 32'h40404040));
    vecs.push_back(mk(1,1,1,0, 32'h00400044, 32'h44444444, 0,0,1, 32'h0,        32'h4,        32'h0));
    vecs.push_back(mk(0,0,0,1, 32'hCAFEF00D, 32'hCAFEF00D, 0,0,1, 32'h0,        32'h4,        32'h0));

    drive(1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].fl, vecs[i].rdy, vecs[i].pc, vecs[i].ins);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_occ, vecs[i].e_vld, vecs[i].e_rdy,
                vecs[i].e_pc, vecs[i].e_p4, vecs[i].e_ins);
    end

    // reset while full with an offer pending; nothing emerges afterwards
    drive(0, 1, 0, 0, 32'h00400100, 32'h01000100); tick();
    drive(0, 1, 0, 0, 32'h00400104, 32'h01000104); tick();
    chk("full.occupancy", 32'(occupancy), 32'd2);
    drive(1, 1, 0, 0, 32'h00400108, 32'h01000108); tick();
    check_all("rst_full", 2'd0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 32'h0, 32'h0); tick();
      chk($sformatf("post_rst%0d.id_valid", k), 32'(id_valid), 32'd0);
      chk($sformatf("post_rst%0d.id_pc", k), id_pc, 32'h0);
    end

    // back-to-back throughput: a fresh PC every cycle, no bubbles
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 1, 32'h00400200 + 32'(k*4), 32'h77000000 + 32'(k)); tick();
      chk($sformatf("tput%0d.id_pc", k), id_pc, 32'h00400200 + 32'(k*4));
      chk($sformatf("tput%0d.id_instr", k), id_instr, 32'h77000000 + 32'(k));
      chk($sformatf("tput%0d.occupancy", k), 32'(occupancy), 32'd1);
    end
    drive(0, 0, 0, 1, 32'h0, 32'h0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
